// File: rtl/sim_periph_bus_pkg.sv
// Shared constants for the simulation peripheral splitter: peripheral addresses,
// control-word bit positions and the drain state encodings.
package sim_periph_bus_pkg;

    localparam logic [31:0] CHAR_OUT_ADDR = 32'h0002_0000;
    localparam logic [31:0] SIM_CTRL_ADDR = 32'h0002_0002;
    localparam logic [29:0] PERI_WORD_DEF = CHAR_OUT_ADDR[31:2];

    // Byte lanes inside the peripheral word follow the low address bits.
    localparam int CHAR_LANE = int'(CHAR_OUT_ADDR[1:0]);
    localparam int CTRL_LANE = int'(SIM_CTRL_ADDR[1:0]);

    localparam int HALT_BIT = 16;
    localparam int EXIT_LSB = 17;
    localparam int EXIT_MSB = 23;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    function automatic logic [31:0] status_word(input logic [7:0] count, input logic halted);
        return {count, 7'b0, halted, 16'b0};
    endfunction

endpackage

// File: rtl/sim_periph_bus_char.sv
// Character FIFO: array storage with a registered head byte, so the consumer
// sees char valid/data straight from flops.
module sim_char_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic [7:0]    push_data,
    output logic          full,
    input  logic          ready,
    output logic          valid,
    output logic [7:0]    head,
    output logic [AW:0]   count
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] wr_ptr_next, rd_ptr_next;
    logic        valid_reg;
    logic [7:0]  head_reg;
    logic        do_push, do_pop, bypass;

    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = valid_reg && ready;

    assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, do_push};
    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, do_pop};

    // The entry being written this cycle becomes the new head when it is next in line.
    assign bypass = do_push && (wr_ptr_reg == rd_ptr_next);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            valid_reg  <= 1'b0;
            head_reg   <= 8'h00;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            valid_reg  <= (wr_ptr_next != rd_ptr_next);
            if (bypass) begin
                head_reg <= push_data;
            end else if (wr_ptr_next != rd_ptr_next) begin
                head_reg <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

    assign valid = valid_reg;
    assign head  = head_reg;

endmodule

// File: rtl/sim_periph_bus.sv
// LSU data-side splitter: RAM pass-through plus the simulation peripheral word
// (char output lane, halt/exit-code lane). Optional cycle counter: SIM_CYCLE_CNT_EN.
module sim_periph_bus
    import sim_periph_bus_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_AW    = 3,
    parameter logic [29:0] PERI_WORD  = PERI_WORD_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        rvalid_o,
    output logic        stall_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_rvalid_i,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i,
    output logic        sim_halt_o,
    output logic [6:0]  exit_code_o
);

    logic [1:0]       state_reg, state_next;
    logic             sim_halt_reg;
    logic [6:0]       exit_code_reg;
    logic             peri_hit, peri_any, halted;
    logic             char_wr, char_push, char_stall, ctrl_wr;
    logic             fifo_full;
    logic [FIFO_AW:0] fifo_count;

    assign peri_hit = ce_i && (addr_i[31:2] == PERI_WORD);
    assign halted   = (state_reg == ST_HALTED);

    assign char_wr    = peri_hit && we_i && sel_i[CHAR_LANE];
    assign char_stall = char_wr && fifo_full && !halted;
    assign char_push  = char_wr && !fifo_full && !halted;

    // A stalled write is retried whole, so its ctrl half waits for the push to land.
    assign ctrl_wr = peri_hit && we_i && sel_i[CTRL_LANE] && data_i[HALT_BIT] &&
                     !char_stall && (state_reg == ST_RUN);

    sim_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (char_push),
        .push_data (data_i[7:0]),
        .full      (fifo_full),
        .ready     (char_ready_i),
        .valid     (char_valid_o),
        .head      (char_data_o),
        .count     (fifo_count)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:    if (ctrl_wr) state_next = ST_DRAIN;
            ST_DRAIN:  if (fifo_count == '0 && !char_push) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_RUN;
            sim_halt_reg  <= 1'b0;
            exit_code_reg <= 7'd0;
        end else begin
            state_reg    <= state_next;
            sim_halt_reg <= halted;
            if (ctrl_wr) begin
                exit_code_reg <= data_i[EXIT_MSB:EXIT_LSB];
            end
        end
    end

`ifdef SIM_CYCLE_CNT_EN
    logic [63:0] cycle_cnt_reg;
    logic        cnt_lo_hit, cnt_hi_hit;

    assign cnt_lo_hit = ce_i && (addr_i[31:2] == PERI_WORD + 30'd1);
    assign cnt_hi_hit = ce_i && (addr_i[31:2] == PERI_WORD + 30'd2);
    assign peri_any   = peri_hit || cnt_lo_hit || cnt_hi_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt_reg <= 64'd0;
        end else if (!halted) begin
            cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
        end
    end
`else
    assign peri_any = peri_hit;
`endif

    always_comb begin
        data_o   = ram_data_i;
        rvalid_o = ram_rvalid_i;
        if (peri_hit && !we_i) begin
            data_o   = status_word(8'(fifo_count), sim_halt_reg);
            rvalid_o = 1'b1;
        end
`ifdef SIM_CYCLE_CNT_EN
        if (cnt_lo_hit && !we_i) begin
            data_o   = cycle_cnt_reg[31:0];
            rvalid_o = 1'b1;
        end
        if (cnt_hi_hit && !we_i) begin
            data_o   = cycle_cnt_reg[63:32];
            rvalid_o = 1'b1;
        end
`endif
    end

    assign stall_o     = char_stall;
    assign ram_ce_o    = ce_i && !peri_any && !sim_halt_reg;
    assign ram_we_o    = we_i;
    assign ram_sel_o   = sel_i;
    assign ram_addr_o  = addr_i;
    assign ram_data_o  = data_i;
    assign sim_halt_o  = sim_halt_reg;
    assign exit_code_o = exit_code_reg;

endmodule
